// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops with per-bit toggle, chained up/down count and
// parallel load. tc is a same-cycle terminal-count flag for cascading banks.
module tff_bank #(
   parameter int unsigned     WIDTH = 4,
   parameter logic [WIDTH-1:0] INIT = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [1:0] MODE_TOGGLE = 2'b00;
   localparam logic [1:0] MODE_UP     = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;
   localparam logic [1:0] MODE_LOAD   = 2'b11;

   logic [WIDTH-1:0] up_t;
   logic [WIDTH-1:0] down_t;
   logic [WIDTH-1:0] tog;

   // T input of each bit in counting modes: AND of all lower (inverted) q bits
   always_comb begin
      up_t      = '0;
      down_t    = '0;
      up_t[0]   = 1'b1;
      down_t[0] = 1'b1;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         up_t[i]   = up_t[i-1] & q[i-1];
         down_t[i] = down_t[i-1] & ~q[i-1];
      end
   end

   always_comb begin
      tog = '0;
      case (mode)
         MODE_TOGGLE: tog = t;
         MODE_UP:     tog = up_t;
         MODE_DOWN:   tog = down_t;
         default:     tog = '0;
      endcase
   end

   assign tc = en & (((mode == MODE_UP) & (&q)) | ((mode == MODE_DOWN) & ~(|q)));

   // wrap is tc delayed one enabled edge, so it never stays high while disabled
   always_ff @(posedge clk) begin
      if (!reset) begin
         q    <= INIT;
         wrap <= 1'b0;
      end else if (!en) begin
         wrap <= 1'b0;
      end else begin
         wrap <= tc;
         if (mode == MODE_LOAD) q <= d;
         else                   q <= q ^ tog;
      end
   end

endmodule
